uart_rx_monitor: RTL

- Parametrised UART receive monitor for the FPGA-level bench and on-chip debug capture.
- Samples the SoC `tx` line and deframes characters with configurable divisor, data width, parity and stop bits.
- Pushes each character, tagged with its parity status, into an internal FIFO that the consumer drains through a valid/ready port.
- Generalises the plain pin hookup of the bench top into a reusable sequential checker with error detection and buffering.

---
 rtl/uart_rx_monitor_pkg.sv | 26 ++
 rtl/uart_rx_monitor_if.sv | 26 ++
 rtl/uart_rx_monitor_fifo.sv | 56 +++++
 rtl/uart_rx_monitor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_monitor_pkg.sv
// Shared types for the UART receive monitor.
// Holds the deframer states, parity modes and the FIFO entry layout.
package uart_rx_monitor_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef struct packed {
        logic                     perr;
        logic [MAX_DATA_BITS-1:0] data;
    } entry_t;

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Consumer-side valid/ready port of the UART receive monitor.
// The monitor drives the master side, the consumer the slave side.
interface uart_rx_monitor_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] data_o;
    logic                 perr_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output data_o,
        output perr_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  perr_o,
        input  valid_o,
        output ready_i
    );

endinterface

// File: rtl/uart_rx_monitor_fifo.sv
// First-word fall-through capture FIFO of entry_t with occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_monitor_fifo
    import uart_rx_monitor_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  entry_t                       entry_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic                         valid_o,
    output logic                         drop_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & ~do_push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= entry_i;
    end

    assign head_o  = empty ? '0 : mem[rptr[AW-1:0]];
    assign valid_o = ~empty;
    assign level_o = wptr - rptr;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: synchroniser, deframer FSM and capture FIFO.
// Characters are tagged with parity status; sticky overflow and frame flags.
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            rx_i,
    input  logic                            clr_i,
    uart_rx_monitor_if.master               deq,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
    output logic                            overflow_o,
    output logic                            frame_err_o,
    output logic                            busy_o
);

    localparam int            CW    = $clog2(CLK_DIV + 1);
    localparam parity_e       PMODE = parity_e'(PARITY);
    localparam logic [CW-1:0] FULL  = CW'(CLK_DIV);
    localparam logic [CW-1:0] HALF  = CW'(CLK_DIV / 2);

    logic                 rx_s1;
    logic                 rx_s;
    logic                 rx_q;
    logic [1:0]           warm;
    logic                 fall;

    state_e               state;
    state_e               state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_cnt_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 perr;
    logic                 perr_n;
    logic                 tick;
    logic                 push;
    logic                 ferr_set;
    logic                 drop;
    entry_t               push_entry;
    entry_t               head;
    logic                 unused_head;

    // Edge history only arms once the synchroniser has flushed its reset
    // value, so a line already low at release never looks like a start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b0;
            warm  <= '0;
        end else begin
            rx_s1 <= rx_i;
            rx_s  <= rx_s1;
            warm  <= {warm[0], 1'b1};
            rx_q  <= warm[1] & rx_s;
        end
    end

    assign fall = rx_q & ~rx_s;
    assign tick = (cnt == CW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            perr    <= perr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        perr_n    = perr;
        push      = 1'b0;
        ferr_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    cnt_n   = HALF;
                    state_n = START;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    cnt_n     = FULL;
                    bit_cnt_n = '0;
                    perr_n    = 1'b0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n   = FULL;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = (PMODE == NONE) ? STOP : PAR;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    perr_n = (PMODE == ODD) ? ~(^shreg ^ rx_s)
                                            :  (^shreg ^ rx_s);
                    cnt_n   = FULL;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rx_s) begin
                    ferr_set = 1'b1;
                    state_n  = IDLE;
                end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    cnt_n     = FULL;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        push_entry                      = '0;
        push_entry.perr                 = perr;
        push_entry.data[DATA_BITS-1:0]  = shreg;
    end

    uart_rx_monitor_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (deq.ready_i),
        .head_o  (head),
        .valid_o (deq.valid_o),
        .drop_o  (drop),
        .level_o (level_o)
    );

    assign deq.data_o  = head.data[DATA_BITS-1:0];
    assign deq.perr_o  = head.perr;
    assign unused_head = ^head.data;
    assign busy_o      = (state != IDLE);

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= drop | (overflow_o & ~clr_i);
            frame_err_o <= ferr_set | (frame_err_o & ~clr_i);
        end
    end

endmodule
